// File: rtl/regfile_pkg.sv
// Shared defaults and types for the multi-port integer register file.
package regfile_pkg;

    localparam int DEF_XLEN  = 32;
    localparam int DEF_NREGS = 32;
    localparam int DEF_NRD   = 2;
    localparam int DEF_NWR   = 2;
    localparam int DEF_AW    = $clog2(DEF_NREGS);

    typedef logic [DEF_AW-1:0]   reg_addr_t;
    typedef logic [DEF_XLEN-1:0] xdata_t;

    // Register 0 is hardwired to zero: never stored, never marked busy.
    localparam int ZERO_REG = 0;

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy tracking for RAW hazard detection between issue and writeback.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter  int NREGS = DEF_NREGS,
    parameter  int NRD   = DEF_NRD,
    parameter  int NWR   = DEF_NWR,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    claim_en,
    input  logic [AW-1:0]           claim_addr,
    input  logic [NWR-1:0]          wr_en,
    input  logic [NWR-1:0][AW-1:0]  wr_addr,
    input  logic [NRD-1:0][AW-1:0]  rd_addr,
    output logic [NREGS-1:0]        busy_vec,
    output logic [NRD-1:0]          rd_busy
);

    logic [NREGS-1:0] busy_next;

    // A claim beats a same-cycle clear: the newly issued producer owns the register.
    always_comb begin
        busy_next = '0;
        for (int a = 1; a < NREGS; a++) begin
            logic set_a;
            logic clr_a;
            set_a = claim_en && (claim_addr == AW'(a));
            clr_a = 1'b0;
            for (int k = 0; k < NWR; k++) begin
                if (wr_en[k] && (wr_addr[k] == AW'(a))) clr_a = 1'b1;
            end
            busy_next[a] = set_a || (busy_vec[a] && !clr_a);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) busy_vec <= '0;
        else     busy_vec <= busy_next;
    end

    // A register being written this cycle is already available through the bypass.
    always_comb begin
        rd_busy = '0;
        for (int i = 0; i < NRD; i++) begin
            logic hit;
            hit = 1'b0;
            for (int k = 0; k < NWR; k++) begin
                if (wr_en[k] && (wr_addr[k] == rd_addr[i])) hit = 1'b1;
            end
            rd_busy[i] = busy_vec[rd_addr[i]] && !hit;
        end
    end

endmodule

// File: rtl/reg_file_mp.sv
// Multi-port register file: posedge-write array, priority write ports, same-cycle bypass, busy scoreboard.
module reg_file_mp
    import regfile_pkg::*;
#(
    parameter  int XLEN  = DEF_XLEN,
    parameter  int NREGS = DEF_NREGS,
    parameter  int NRD   = DEF_NRD,
    parameter  int NWR   = DEF_NWR,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NRD-1:0][AW-1:0]   rd_addr,
    output logic [NRD-1:0][XLEN-1:0] rd_data,
    output logic [NRD-1:0]           rd_busy,
    input  logic [NWR-1:0]           wr_en,
    input  logic [NWR-1:0][AW-1:0]   wr_addr,
    input  logic [NWR-1:0][XLEN-1:0] wr_data,
    input  logic                     claim_en,
    input  logic [AW-1:0]            claim_addr,
    output logic [NREGS-1:0]         busy_vec
);

    logic [XLEN-1:0] regs [NREGS];

    // Ports are visited in ascending order, so the highest-index writer's update lands last.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < NREGS; r++) regs[r] <= '0;
        end else begin
            for (int k = 0; k < NWR; k++) begin
                if (wr_en[k] && (wr_addr[k] != AW'(ZERO_REG))) regs[wr_addr[k]] <= wr_data[k];
            end
        end
    end

    // Bypass priority matches the write priority: later ports override earlier ones.
    always_comb begin
        rd_data = '0;
        for (int i = 0; i < NRD; i++) begin
            rd_data[i] = regs[rd_addr[i]];
            for (int k = 0; k < NWR; k++) begin
                if (wr_en[k] && (wr_addr[k] == rd_addr[i])) rd_data[i] = wr_data[k];
            end
            if (rd_addr[i] == AW'(ZERO_REG)) rd_data[i] = '0;
        end
    end

    regfile_scoreboard #(
        .NREGS (NREGS),
        .NRD   (NRD),
        .NWR   (NWR)
    ) u_scoreboard (
        .clk        (clk),
        .rst        (rst),
        .claim_en   (claim_en),
        .claim_addr (claim_addr),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .rd_addr    (rd_addr),
        .busy_vec   (busy_vec),
        .rd_busy    (rd_busy)
    );

endmodule

// File: doc/reg_file_mp.md
# reg_file_mp

Parametrised multi-port integer register file for the pipelined core. It replaces the single-write, negedge-write register file with a posedge-write array. Its features:
- configurable width, depth, read-port count and write-port count;
- same-cycle write-to-read bypass;
- a per-register busy scoreboard that the issue stage uses to detect RAW hazards against in-flight writebacks.

It sits between decode/issue (reads, claims) and writeback (writes).

## Interface
- XLEN, 32: register data width in bits
- NREGS, 32: number of architectural registers (power of two, ≥ 2); register 0 hardwired to zero
- NRD, 2: number of read ports
- NWR, 2: number of write ports
- AW, $clog2(NREGS): register address width (derived, not overridden)

Reset and clock (already decided): one clock; reset is synchronous and active-high.
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- rd_addr  in  NRD×AW  read address per port
- rd_data  out  NRD×XLEN  read data per port (combinational)
- rd_busy  out  NRD  scoreboard busy for the register addressed by each read port (combinational)
- wr_en  in  NWR  write enable per port
- wr_addr  in  NWR×AW  write address per port
- wr_data  in  NWR×XLEN  write data per port
- claim_en  in  1  issue stage marks a destination as pending
- claim_addr  in  AW  destination register being claimed
- busy_vec  out  NREGS  registered scoreboard state, bit i = register i pending

## Operation
Reset:
- rst=1 clears all NREGS registers to 0 and all busy bits to 0 at the next edge.
- Reset overrides writes and claims in the same cycle.
- There is no file preload.

Writes:
- Port k with wr_en[k]=1 and wr_addr[k]≠0 updates the array at the rising edge.
- Writes to address 0 are discarded.

Write-port conflict:
- Several ports writing the same address in one cycle is legal.
- The highest-index port wins; the others are dropped silently.

Reads:
- rd_data[i] = 0 when rd_addr[i]=0.
- Otherwise, if any enabled write port targets rd_addr[i] this cycle, rd_data[i] = wr_data of the highest-index such port (bypass).
- Otherwise rd_data[i] = the array content.

Scoreboard:
- A claim with claim_en=1 and claim_addr≠0 sets busy[claim_addr].
- Any enabled write to address a≠0 clears busy[a].
- A claim and a write to the same address in the same cycle leave busy=1, because the new producer wins.
- Claims to address 0 are ignored, so busy[0] is constantly 0.

rd_busy:
- rd_busy[i] = busy[rd_addr[i]] & ~(a same-cycle enabled write targets rd_addr[i]).
- The bypassed value is therefore reported not busy.
- A same-cycle claim does not raise rd_busy; the claim is only visible from the next cycle.

Protocol:
- Writing an unclaimed register is legal: the data is stored and busy is unchanged (0).
- The block performs no protocol checking.

## Timing
- Write latency:
  - 1 edge to the array;
  - 0 cycles to rd_data through the bypass.
- Read latency: 0 cycles (combinational from rd_addr, wr_*).
- Scoreboard timing:
  - claim at edge N → busy_vec bit high from cycle N+1;
  - write at edge M → bit low from cycle M+1.
  - rd_busy drops in cycle M itself because of the bypass mask.
- Reset values: all registers 0, busy_vec = 0.
  - While rst is held, rd_data reflects the array contents plus the bypass, not forced 0.
  - The first cycle after rst deasserts reads 0 from every register.
- Reset mid-operation: pending claims are lost, so busy_vec=0 after reset. Upstream must flush the pipeline together with rst.
- No multi-cycle paths. The bypass mux depth is NWR priority levels.

## Structure
Package regfile_pkg:
- default XLEN/NREGS/NRD/NWR localparams;
- typedef reg_addr_t (logic [AW-1:0]);
- typedef xdata_t (logic [XLEN-1:0]);
- ZERO_REG constant.

Sub-modules:
- regfile_scoreboard: owns busy_vec, the claim/clear priority and rd_busy masking. Inputs are claim_*, wr_en/wr_addr and rd_addr.
- The top level holds the data array, the write-port priority resolution and the bypass muxes.

## Test plan
- Reset then read all ports: rst for 2 cycles, then rd_addr = {5, 31} → rd_data = {0, 0}, busy_vec = 0.
- Write/bypass: wr_en[0]=1, wr_addr=7, wr_data=0xDEADBEEF with rd_addr[0]=7 in the same cycle → rd_data[0]=0xDEADBEEF in that cycle, and still 0xDEADBEEF in the next cycle with wr_en=0.
- Port conflict: both ports write address 3, port0=0x11 and port1=0x22 → same-cycle bypass gives 0x22, array holds 0x22 afterwards.
- x0: write 0xFFFFFFFF and claim address 0 → rd_data=0, busy_vec[0]=0.
- Scoreboard:
  - claim 9 at edge N → busy_vec[9]=1 at N+1 and rd_busy=1 when reading 9;
  - write 9=0x55 at cycle M → rd_busy=0 and rd_data=0x55 in cycle M, busy_vec[9]=0 at M+1;
  - claim plus write of 9 in the same cycle → busy_vec[9]=1 afterwards.
- Reset mid-operation: claim registers 4 and 6, write 4=0xAA, assert rst with a simultaneous write 6=0xBB → everything reads 0 and busy_vec=0 after reset.
